// File: rtl/jvm_byte_fetch_if.sv
// Bus bundle between the bytecode fetch stage, the input RAM and the translator.
// The slave modport is the fetch stage; the master modport is its environment.
interface jvm_byte_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] byte_count;
    logic              flush;
    logic              iram_re;
    logic [ADDR_W-1:0] iram_addr;
    logic [7:0]        iram_rdata;
    logic [7:0]        byte_out;
    logic [ADDR_W-1:0] byte_pc;
    logic              byte_valid;
    logic              byte_ready;
    logic              busy;
    logic              done;

    modport slave (
        input  start, start_addr, byte_count, flush, iram_rdata, byte_ready,
        output iram_re, iram_addr, byte_out, byte_pc, byte_valid, busy, done
    );

    modport master (
        output start, start_addr, byte_count, flush, iram_rdata, byte_ready,
        input  iram_re, iram_addr, byte_out, byte_pc, byte_valid, busy, done
    );
endinterface

// File: rtl/jvm_byte_fetch.sv
// JVM bytecode fetch stage: streams bytes from the byte-wide input RAM into a
// small prefetch FIFO and presents them, with their addresses, on a
// valid/ready handshake. All outputs are registered.
module jvm_byte_fetch #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    jvm_byte_fetch_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] r_remaining;   // reads still to issue
    logic              r_iram_re;
    logic [ADDR_W-1:0] r_iram_addr;
    logic              r_rd_pend;     // read data is on iram_rdata this cycle
    logic [ADDR_W-1:0] r_pend_pc;
    logic [7:0]        r_mem_data [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_cnt;         // entries held, including the output head
    logic [7:0]        r_byte_out;
    logic [ADDR_W-1:0] r_byte_pc;
    logic              r_byte_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_pop;
    logic              w_push;
    logic [CW-1:0]     w_cnt_pop;
    logic [CW-1:0]     w_cnt_next;
    logic [PW-1:0]     w_rd_ptr_next;
    logic [CW:0]       w_occ;
    logic              w_room;
    logic              w_issue;
    logic              w_last;
    logic              w_flush;
    logic [7:0]        w_head_data;
    logic [ADDR_W-1:0] w_head_pc;

    assign w_pop         = r_byte_valid && bus.byte_ready;
    assign w_push        = r_rd_pend;
    assign w_cnt_pop     = r_cnt - CW'(w_pop);
    assign w_cnt_next    = w_cnt_pop + CW'(w_push);
    assign w_rd_ptr_next = r_rd_ptr + PW'(w_pop);
    // Space check counts the read already strobed this cycle, which lands next edge.
    assign w_occ         = {1'b0, w_cnt_next} + (CW+1)'(r_iram_re);
    assign w_room        = w_occ < (CW+1)'(DEPTH);
    assign w_issue       = (r_state == S_FETCH) && (r_remaining != '0) && w_room;
    assign w_last        = (r_state == S_DRAIN) && w_pop && (w_cnt_next == '0) && !r_iram_re;
    assign w_flush       = (r_state != S_IDLE) && bus.flush;

    // Next head: bypass the returning byte when the FIFO would otherwise be empty.
    always_comb begin
        w_head_data = r_mem_data[w_rd_ptr_next];
        w_head_pc   = r_mem_pc[w_rd_ptr_next];
        if (w_push && (w_cnt_pop == '0)) begin
            w_head_data = bus.iram_rdata;
            w_head_pc   = r_pend_pc;
        end
    end

    // FIFO storage; write pointer and count are kept with the control state.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus.iram_rdata;
            r_mem_pc[r_wr_ptr]   <= r_pend_pc;
        end
    end

    // Control FSM, read issue, FIFO pointers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_next_addr  <= '0;
            r_remaining  <= '0;
            r_iram_re    <= 1'b0;
            r_iram_addr  <= '0;
            r_rd_pend    <= 1'b0;
            r_pend_pc    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_byte_out   <= '0;
            r_byte_pc    <= '0;
            r_byte_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_flush) begin
                // Abort: drop FIFO contents and the pending return, no done pulse.
                r_state      <= S_IDLE;
                r_remaining  <= '0;
                r_iram_re    <= 1'b0;
                r_rd_pend    <= 1'b0;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_cnt        <= '0;
                r_byte_valid <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                r_rd_pend    <= r_iram_re;
                r_pend_pc    <= r_iram_addr;
                r_iram_re    <= 1'b0;
                r_rd_ptr     <= w_rd_ptr_next;
                r_cnt        <= w_cnt_next;
                r_byte_valid <= (w_cnt_next != '0);
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_cnt_next != '0) begin
                    r_byte_out <= w_head_data;
                    r_byte_pc  <= w_head_pc;
                end
                case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.flush) begin
                            if (bus.byte_count == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                // First read goes out on the accepting edge.
                                r_iram_re   <= 1'b1;
                                r_iram_addr <= bus.start_addr;
                                r_next_addr <= bus.start_addr + ADDR_W'(1);
                                r_remaining <= bus.byte_count - ADDR_W'(1);
                                r_state     <= (bus.byte_count == ADDR_W'(1)) ? S_DRAIN : S_FETCH;
                                r_busy      <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (w_issue) begin
                            r_iram_re   <= 1'b1;
                            r_iram_addr <= r_next_addr;
                            r_next_addr <= r_next_addr + ADDR_W'(1);
                            r_remaining <= r_remaining - ADDR_W'(1);
                            if (r_remaining == ADDR_W'(1))
                                r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.iram_re    = r_iram_re;
    assign bus.iram_addr  = r_iram_addr;
    assign bus.byte_out   = r_byte_out;
    assign bus.byte_pc    = r_byte_pc;
    assign bus.byte_valid = r_byte_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_jvm_byte_fetch.sv
// Bench for jvm_byte_fetch: a RAM model with one-cycle read latency and an
// expected byte stream built directly from the RAM image (byte i of a run is
// RAM[start_addr + i mod 2^16] with pc = that address).
module tb_jvm_byte_fetch;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   reads = 0;
    logic [7:0] ram [65536];

    always #5 clk = ~clk;

    jvm_byte_fetch_if bus ();

    jvm_byte_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Input RAM: data for a strobe in cycle n is on iram_rdata in cycle n+1.
    always @(posedge clk) begin
        if (bus.iram_re) bus.iram_rdata <= ram[bus.iram_addr];
    end

    // Read strobe counter, sampled by the stimulus as deltas.
    always @(posedge clk) begin
        if (bus.iram_re) reads <= reads + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_iram_re",    {31'd0, bus.iram_re},    32'd0);
        chk("rst_iram_addr",  {16'd0, bus.iram_addr},  32'd0);
        chk("rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
        chk("rst_byte_out",   {24'd0, bus.byte_out},   32'd0);
        chk("rst_byte_pc",    {16'd0, bus.byte_pc},    32'd0);
        chk("rst_busy",       {31'd0, bus.busy},       32'd0);
        chk("rst_done",       {31'd0, bus.done},       32'd0);
    endtask

    // One complete run against the expected stream.
    // pct: chance (percent) of byte_ready per cycle; hold: cycles of ready low
    // after the first valid byte; bs: pulse a stray start mid-run.
    task automatic do_run(input logic [15:0] sa, input logic [15:0] n,
                          input int pct, input int hold, input bit bs);
        int r0, idx, cyc, first, lastc, held;
        logic [15:0] a;
        r0 = reads; idx = 0; first = -1; lastc = -1; held = 0;
        bus.start_addr = sa;
        bus.byte_count = n;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        if (n == 16'd0) begin
            chk("zero_done",  {31'd0, bus.done},    32'd1);
            chk("zero_busy",  {31'd0, bus.busy},    32'd0);
            chk("zero_re",    {31'd0, bus.iram_re}, 32'd0);
            tick();
            chk("zero_done_off", {31'd0, bus.done}, 32'd0);
            chk("zero_reads", reads - r0, 32'd0);
            return;
        end
        chk("start_busy", {31'd0, bus.busy},      32'd1);
        chk("start_re",   {31'd0, bus.iram_re},   32'd1);
        chk("start_addr", {16'd0, bus.iram_addr}, {16'd0, sa});
        while (idx < int'(n) && cyc < 4000) begin
            if (bus.byte_valid && first < 0) first = cyc;
            if (bs && cyc == 2) begin
                bus.start      = 1'b1;
                bus.start_addr = sa ^ 16'h5555;
                bus.byte_count = 16'd3;
            end
            if (first >= 0 && held < hold) begin
                bus.byte_ready = 1'b0;
                held++;
                chk("bp_hold_byte", {24'd0, bus.byte_out}, {24'd0, ram[sa]});
                chk("bp_hold_pc",   {16'd0, bus.byte_pc},  {16'd0, sa});
                if (held == hold)
                    chk("bp_reads", reads - r0, (int'(n) < 4) ? n : 32'd4);
            end else begin
                bus.byte_ready = ($urandom_range(99) < pct);
            end
            if (bus.byte_valid && bus.byte_ready) begin
                a = sa + 16'(idx);
                chk("run_byte", {24'd0, bus.byte_out}, {24'd0, ram[a]});
                chk("run_pc",   {16'd0, bus.byte_pc},  {16'd0, a});
                idx++;
                lastc = cyc;
            end
            chk("run_busy", {31'd0, bus.busy}, 32'd1);
            chk("run_done", {31'd0, bus.done}, 32'd0);
            tick();
            bus.start = 1'b0;
            cyc++;
        end
        bus.byte_ready = 1'b0;
        chk("run_count", idx, {16'd0, n});
        chk("end_done",  {31'd0, bus.done}, 32'd1);
        chk("end_busy",  {31'd0, bus.busy}, 32'd0);
        chk("end_reads", reads - r0, {16'd0, n});
        if (pct == 100 && hold == 0) begin
            chk("latency",   first, 32'd3);
            chk("no_bubble", lastc - first, int'(n) - 1);
        end
        tick();
        chk("done_pulse", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int idx, guard;
        logic [15:0] a;
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.byte_count = '0;
        bus.flush      = 1'b0;
        bus.byte_ready = 1'b0;
        bus.iram_rdata = '0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) ram[16'h0100 + i] = 8'(8'h10 + i);

        #12;
        chk_reset_vals();
        reset = 1'b1;
        tick();

        // Basic run, full throughput.
        do_run(16'h0100, 16'd6, 100, 0, 1'b0);
        // Backpressure: ready low for 10 cycles after the first valid byte.
        do_run(16'h0100, 16'd6, 100, 10, 1'b0);
        // Zero-length run.
        do_run(16'h1234, 16'd0, 100, 0, 1'b0);
        // Address wrap.
        do_run(16'hFFFE, 16'd4, 100, 0, 1'b0);
        // Single byte.
        do_run(16'h0777, 16'd1, 100, 0, 1'b0);
        // Stray start while busy must not disturb the run.
        do_run(16'h0900, 16'd8, 100, 0, 1'b1);

        // start + flush in IDLE: start dropped.
        bus.start_addr = 16'h0A00;
        bus.byte_count = 16'd5;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("sf_idle_busy", {31'd0, bus.busy},    32'd0);
        chk("sf_idle_re",   {31'd0, bus.iram_re}, 32'd0);
        tick();
        chk("sf_idle_done", {31'd0, bus.done},    32'd0);

        // Flush mid-run with a read in flight, start asserted alongside.
        bus.start_addr = 16'h0300;
        bus.byte_count = 16'd20;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.byte_ready = 1'b1;
        idx = 0; guard = 0;
        while (idx < 5 && guard < 50) begin
            if (bus.byte_valid) begin
                a = 16'h0300 + 16'(idx);
                chk("fl_byte", {24'd0, bus.byte_out}, {24'd0, ram[a]});
                idx++;
            end
            tick();
            guard++;
        end
        chk("fl_pre_count", idx, 32'd5);
        chk("fl_inflight",  {31'd0, bus.iram_re}, 32'd1);
        bus.byte_ready = 1'b0;
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.start_addr = 16'h0500;
        tick();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk("fl_valid", {31'd0, bus.byte_valid}, 32'd0);
        chk("fl_busy",  {31'd0, bus.busy},       32'd0);
        chk("fl_done",  {31'd0, bus.done},       32'd0);
        tick();
        chk("fl_valid2", {31'd0, bus.byte_valid}, 32'd0);
        chk("fl_busy2",  {31'd0, bus.busy},       32'd0);
        chk("fl_re2",    {31'd0, bus.iram_re},    32'd0);
        chk("fl_done2",  {31'd0, bus.done},       32'd0);
        do_run(16'h0200, 16'd7, 100, 0, 1'b0);

        // Asynchronous reset between edges, mid-run.
        bus.start_addr = 16'h0400;
        bus.byte_count = 16'd12;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #3;
        reset = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        reset = 1'b1;
        bus.byte_ready = 1'b0;
        tick();
        tick();
        chk("post_rst_valid", {31'd0, bus.byte_valid}, 32'd0);
        chk("post_rst_busy",  {31'd0, bus.busy},       32'd0);

        // Randomized runs with random backpressure.
        for (int k = 0; k < 8; k++)
            do_run(16'($urandom), 16'($urandom_range(40, 1)), 30 + 10 * k, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jvm_byte_fetch.md
# jvm_byte_fetch

Upstream bytecode fetch stage for the JVM-to-ARM translator (`acc`). It streams JVM bytecode out of the byte-wide input RAM into a small prefetch FIFO and hands bytes to the translator one at a time over a valid/ready handshake. Each byte is delivered together with its bytecode address. The block hides the input RAM's one-cycle read latency and translator stalls, so the translator sees a continuous byte stream starting at a programmed address for a programmed length.

## Interface
Parameters:
- `ADDR_W`, default 16: input RAM byte-address width and length-counter width.
- `DEPTH`, default 4: prefetch FIFO entries. Must be a power of 2 and at least 4.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a fetch run. Sampled only in IDLE.
- `start_addr`  in  ADDR_W  first byte address of the run, latched on an accepted `start`.
- `byte_count`  in  ADDR_W  number of bytes in the run, latched on an accepted `start`.
- `flush`  in  1  aborts the current run (e.g. on translator redirect).
- `iram_re`  out  1  input RAM read strobe.
- `iram_addr`  out  ADDR_W  input RAM read address.
- `iram_rdata`  in  8  read data, valid exactly one cycle after `iram_re`.
- `byte_out`  out  8  FIFO head byte.
- `byte_pc`  out  ADDR_W  bytecode address of `byte_out`.
- `byte_valid`  out  1  `byte_out` and `byte_pc` are valid.
- `byte_ready`  in  1  translator accepts the byte.
- `busy`  out  1  high whenever the block is not in IDLE.
- `done`  out  1  one-cycle pulse after the last byte of a run is accepted.

## Operation
- The FSM has three states: IDLE, FETCH and DRAIN.
- **IDLE → FETCH:** `start` with `byte_count != 0`. On this transition the block loads `next_addr = start_addr` and `remaining = byte_count`.
- **IDLE, zero-length run:** `start` with `byte_count == 0` produces a `done` pulse in the following cycle. No reads are issued and the FSM stays in IDLE.
- **Issuing reads in FETCH:** `iram_re` is asserted when `remaining != 0` and `occupancy + inflight < DEPTH`.
  - `inflight` is 0 or 1 and marks a read whose data returns in the next cycle.
  - Each issued read drives `iram_addr = next_addr`, then increments `next_addr` modulo 2^ADDR_W (wraps from all-ones to 0) and decrements `remaining`.
- **FIFO write:** returning data is written into the FIFO together with its address; `byte_pc` is the issue-time `next_addr` carried alongside the data.
- **FETCH → DRAIN:** taken when the final read is issued (`remaining` becomes 0).
- **DRAIN → IDLE:** taken on the handshake of the last byte, once there are no inflight reads and the FIFO is empty after the pop. `done` pulses in the next cycle.
- **Handshake:** a byte transfers on any cycle with `byte_valid && byte_ready`. `byte_out` and `byte_pc` hold steady while `byte_valid && !byte_ready`.
- **Simultaneous push and pop:** allowed on the same edge, including when the FIFO is full; the count is unchanged.
- **Flush:** `flush` in FETCH or DRAIN empties the FIFO, discards any inflight return (it is never written), clears `remaining` and returns to IDLE. No `done` pulse is produced. `flush` in IDLE has no effect.
- **Start while busy:** `start` is ignored outside IDLE. If `start` and `flush` occur in the same cycle, `flush` wins and `start` is dropped.
- **Reset values:** `iram_re=0`, `iram_addr=0`, `byte_valid=0`, `byte_out=0`, `byte_pc=0`, `busy=0`, `done=0`, FSM=IDLE, FIFO empty, `inflight=0`.
- **Reset mid-run:** all state is cleared immediately. A RAM read return that arrives after reset is ignored.

## Timing
- **Start to first read:** `start` is sampled at edge E. `iram_re` goes high in the cycle after E with `iram_addr=start_addr`.
- **Read latency:** data from a read strobed in cycle n is written into the FIFO at the end of cycle n+1. `byte_valid` rises in cycle n+2.
- **Latency:** 3 cycles from the sampled `start` edge to the first `byte_valid`.
- **Throughput:** with `byte_ready` held high, the block sustains one byte per cycle with no bubbles. `DEPTH=4` covers the read latency plus the registered output.
- **Backpressure:** with `byte_ready` low, at most `DEPTH` bytes are fetched ahead and `iram_re` stays low until space frees up.
- **`busy`:** rises in the cycle after an accepted `start` and falls in the same cycle as the `done` pulse.
- **Outputs:** all outputs are registered. There is no combinational path from `byte_ready` or `iram_rdata` to any output.

## Test plan
- **Basic run:** RAM[0x0100..0x0105] = 10 11 12 13 14 15, `start_addr=0x0100`, `byte_count=6`, `byte_ready=1` → bytes 10..15 with `byte_pc` 0x0100..0x0105 on six consecutive cycles, first `byte_valid` 3 cycles after `start`, `done` one cycle after the last byte, `busy` high throughout.
- **Backpressure:** same run with `byte_ready` low for 10 cycles after the first `byte_valid` → exactly 4 reads issued and `iram_re` then stays low; `byte_out` holds 10; after release the bytes arrive in order with no loss or duplication.
- **Zero length:** `start` with `byte_count=0` → no `iram_re`, `done` pulses in the next cycle, `busy` stays 0.
- **Address wrap:** `start_addr=0xFFFE`, `byte_count=4` → reads at FFFE, FFFF, 0000, 0001 and matching `byte_pc` values.
- **Flush mid-run:** `byte_count=20`; assert `flush` together with an inflight read after 5 bytes are accepted → next cycle `byte_valid=0` and `busy=0`, no `done`; a fresh `start` at 0x0200 then delivers RAM[0x0200] first.
- **Async reset:** drop `reset` low mid-run between clock edges → outputs reach their reset values immediately; `start` ignored while busy, and `start`+`flush` in the same cycle, are both checked to leave the run unchanged or aborted as specified.
